// File: rtl/mod_147_5_pkg.sv
// Shared 10BASE-T1S PCS definitions: 5B symbol codes, PLCA/RS command
// encodings, link control values and the 4B5B data encoder.
package mod_147_5_pkg;

    localparam logic [4:0] SYM_SILENCE = 5'b11111;
    localparam logic [4:0] SYM_SYNC    = 5'b11000;
    localparam logic [4:0] SYM_SSD     = 5'b10001;
    localparam logic [4:0] SYM_ESD     = 5'b01101;
    localparam logic [4:0] SYM_ESDOK   = 5'b00111;
    localparam logic [4:0] SYM_ESDERR  = 5'b11001;
    localparam logic [4:0] SYM_ESDBRS  = 5'b00110;
    localparam logic [4:0] SYM_HB      = 5'b00101;
    localparam logic [4:0] SYM_BEACON  = 5'b01000;
    localparam logic [4:0] SYM_HALT    = 5'b00100;

    typedef enum logic [1:0] {
        CMD_NONE      = 2'd0,
        CMD_COMMIT    = 2'd1,
        CMD_BEACON    = 2'd2,
        CMD_HEARTBEAT = 2'd3
    } tx_cmd_t;

    localparam logic LINK_DISABLE = 1'b0;
    localparam logic LINK_ENABLE  = 1'b1;

    // 4B5B data code; the inverse of the receive-side DECODE.
    function automatic logic [4:0] encode(input logic [3:0] nibble);
        logic [4:0] code;
        case (nibble)
            4'h0: code = 5'b11110;
            4'h1: code = 5'b01001;
            4'h2: code = 5'b10100;
            4'h3: code = 5'b10101;
            4'h4: code = 5'b01010;
            4'h5: code = 5'b01011;
            4'h6: code = 5'b01110;
            4'h7: code = 5'b01111;
            4'h8: code = 5'b10010;
            4'h9: code = 5'b10011;
            4'hA: code = 5'b10110;
            4'hB: code = 5'b10111;
            4'hC: code = 5'b11010;
            4'hD: code = 5'b11011;
            4'hE: code = 5'b11100;
            default: code = 5'b11101;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/mod_147_5.sv
// 10BASE-T1S PCS transmit state machine: turns MII nibbles and PLCA/RS
// commands into one 5B symbol per STD strobe.
module mod_147_5
    import mod_147_5_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       STD,
    input  logic       pcs_reset,
    input  logic       link_control,
    input  logic       TX_EN,
    input  logic       TX_ER,
    input  logic [3:0] TXD,
    input  logic [1:0] tx_cmd,
    output logic [4:0] TXn,
    output logic       transmitting,
    output logic       tx_err,
    output logic [3:0] mod_147_5_state
);

    typedef enum logic [3:0] {
        SILENT     = 4'd0,
        COMMIT_ST  = 4'd1,
        SYNC1      = 4'd2,
        SYNC2      = 4'd3,
        SSD1       = 4'd4,
        SSD2       = 4'd5,
        DATA       = 4'd6,
        HALT_ST    = 4'd7,
        ESD_ST     = 4'd8,
        ESD_STATUS = 4'd9,
        HEARTBEAT  = 4'd10,
        BEACON_ST  = 4'd11
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [4:0] sym_nxt;
    logic       err_nxt;
    logic       min_cnt;
    logic       min_nxt;

    always_comb begin
        // NOTE: every output of this block gets a default first so no path can infer a latch.
        state_nxt = state;
        sym_nxt   = TXn;
        err_nxt   = tx_err;
        min_nxt   = min_cnt;
        case (state)
            SILENT: begin
                sym_nxt = SYM_SILENCE;
                if (TX_EN) begin
                    state_nxt = SYNC1;
                    sym_nxt   = SYM_SYNC;
                    err_nxt   = 1'b0;
                end else if (tx_cmd == CMD_COMMIT) begin
                    state_nxt = COMMIT_ST;
                    sym_nxt   = SYM_SYNC;
                end else if (tx_cmd == CMD_BEACON) begin
                    state_nxt = BEACON_ST;
                    sym_nxt   = SYM_BEACON;
                    min_nxt   = 1'b1;
                end else if (tx_cmd == CMD_HEARTBEAT) begin
                    state_nxt = HEARTBEAT;
                    sym_nxt   = SYM_HB;
                    min_nxt   = 1'b1;
                end
            end
            COMMIT_ST: begin
                if (TX_EN) begin
                    state_nxt = SYNC1;
                    sym_nxt   = SYM_SYNC;
                    err_nxt   = 1'b0;
                end else if (tx_cmd != CMD_COMMIT) begin
                    state_nxt = SILENT;
                    sym_nxt   = SYM_SILENCE;
                end else begin
                    sym_nxt = SYM_SYNC;
                end
            end
            SYNC1, SYNC2, SSD1: begin
                if (!TX_EN) begin
                    // Runt frame: ended before any data nibble was encoded.
                    state_nxt = ESD_ST;
                    sym_nxt   = SYM_ESD;
                    err_nxt   = 1'b1;
                end else begin
                    err_nxt = tx_err | TX_ER;
                    case (state)
                        SYNC1: begin
                            state_nxt = SYNC2;
                            sym_nxt   = SYM_SYNC;
                        end
                        SYNC2: begin
                            state_nxt = SSD1;
                            sym_nxt   = SYM_SSD;
                        end
                        default: begin
                            state_nxt = SSD2;
                            sym_nxt   = SYM_SSD;
                        end
                    endcase
                end
            end
            SSD2, DATA, HALT_ST: begin
                if (!TX_EN) begin
                    state_nxt = ESD_ST;
                    sym_nxt   = SYM_ESD;
                    err_nxt   = tx_err | (state == SSD2);
                end else if (TX_ER) begin
                    state_nxt = HALT_ST;
                    sym_nxt   = SYM_HALT;
                    err_nxt   = 1'b1;
                end else begin
                    state_nxt = DATA;
                    sym_nxt   = encode(TXD);
                end
            end
            ESD_ST: begin
                state_nxt = ESD_STATUS;
                sym_nxt   = tx_err ? SYM_ESDERR : SYM_ESDOK;
            end
            HEARTBEAT, BEACON_ST: begin
                if (min_cnt) begin
                    // Second mandatory symbol; TX_EN and tx_cmd are not looked at yet.
                    min_nxt = 1'b0;
                end else if (TX_EN) begin
                    state_nxt = SYNC1;
                    sym_nxt   = SYM_SYNC;
                    err_nxt   = 1'b0;
                end else if ((state == HEARTBEAT && tx_cmd != CMD_HEARTBEAT) ||
                             (state == BEACON_ST && tx_cmd != CMD_BEACON)) begin
                    state_nxt = SILENT;
                    sym_nxt   = SYM_SILENCE;
                end
            end
            default: begin
                state_nxt = SILENT;
                sym_nxt   = SYM_SILENCE;
            end
        endcase
    end

    // pcs_reset and DISABLE act on every clk, not only on STD.
    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!reset_n) begin
            state        <= SILENT;
            TXn          <= SYM_SILENCE;
            transmitting <= 1'b0;
            tx_err       <= 1'b0;
            min_cnt      <= 1'b0;
        end else if (pcs_reset || link_control == LINK_DISABLE) begin
            state        <= SILENT;
            TXn          <= SYM_SILENCE;
            transmitting <= 1'b0;
            tx_err       <= 1'b0;
            min_cnt      <= 1'b0;
        end else if (STD) begin
            state        <= state_nxt;
            TXn          <= sym_nxt;
            transmitting <= (sym_nxt != SYM_SILENCE);
            tx_err       <= err_nxt;
            min_cnt      <= min_nxt;
        end
    end

    assign mod_147_5_state = state;

endmodule

// File: tb/tb_mod_147_5.sv
// Self-checking bench for mod_147_5: directed frames with literal symbol
// expectations plus randomized traffic against a nibble-counting model.
module tb_mod_147_5;
    import mod_147_5_pkg::*;

    logic       clk          = 1'b0;
    logic       reset_n      = 1'b0;
    logic       STD          = 1'b0;
    logic       pcs_reset    = 1'b0;
    logic       link_control = LINK_ENABLE;
    logic       TX_EN        = 1'b0;
    logic       TX_ER        = 1'b0;
    logic [3:0] TXD          = 4'h0;
    logic [1:0] tx_cmd       = 2'd0;
    logic [4:0] TXn;
    logic       transmitting;
    logic       tx_err;
    logic [3:0] mod_147_5_state;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;
    int tx_stds  = 0;

    always #5 clk = ~clk;

    mod_147_5 dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .STD             (STD),
        .pcs_reset       (pcs_reset),
        .link_control    (link_control),
        .TX_EN           (TX_EN),
        .TX_ER           (TX_ER),
        .TXD             (TXD),
        .tx_cmd          (tx_cmd),
        .TXn             (TXn),
        .transmitting    (transmitting),
        .tx_err          (tx_err),
        .mod_147_5_state (mod_147_5_state)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, exp);
        end
    endtask

    // Behavioural model: tracks what kind of activity is on the line and how
    // many nibbles of the current frame have been consumed.
    localparam int M_IDLE = 0, M_CMD = 1, M_FRAME = 2, M_STATUS = 3, M_DRAIN = 4;
    int         m_mode = M_IDLE;
    int         m_pos  = 0;
    logic [1:0] m_cmd  = 2'd0;
    bit         m_hold = 1'b0;
    bit         m_err  = 1'b0;
    logic [4:0] m_sym  = SYM_SILENCE;
    logic [4:0] enc_tab [16] = '{5'b11110, 5'b01001, 5'b10100, 5'b10101,
                                 5'b01010, 5'b01011, 5'b01110, 5'b01111,
                                 5'b10010, 5'b10011, 5'b10110, 5'b10111,
                                 5'b11010, 5'b11011, 5'b11100, 5'b11101};

    function automatic logic [4:0] cmd_sym(input logic [1:0] c);
        if (c == CMD_COMMIT) return SYM_SYNC;
        if (c == CMD_BEACON) return SYM_BEACON;
        return SYM_HB;
    endfunction

    task automatic model_reset();
        m_mode = M_IDLE;
        m_hold = 1'b0;
        m_err  = 1'b0;
        m_sym  = SYM_SILENCE;
    endtask

    task automatic model_start();
        m_mode = M_FRAME;
        m_pos  = 1;
        m_err  = 1'b0;
        m_sym  = SYM_SYNC;
    endtask

    task automatic model_step();
        case (m_mode)
            M_IDLE: begin
                if (TX_EN) model_start();
                else if (tx_cmd != CMD_NONE) begin
                    m_mode = M_CMD;
                    m_cmd  = tx_cmd;
                    m_hold = (tx_cmd != CMD_COMMIT);
                    m_sym  = cmd_sym(tx_cmd);
                end else m_sym = SYM_SILENCE;
            end
            M_CMD: begin
                if (m_hold) m_hold = 1'b0;
                else if (TX_EN) model_start();
                else if (tx_cmd != m_cmd) begin
                    m_mode = M_IDLE;
                    m_sym  = SYM_SILENCE;
                end
            end
            M_FRAME: begin
                if (!TX_EN) begin
                    if (m_pos < 5) m_err = 1'b1;
                    m_sym  = SYM_ESD;
                    m_mode = M_STATUS;
                end else begin
                    m_pos++;
                    if (m_pos <= 4) begin
                        if (TX_ER) m_err = 1'b1;
                        m_sym = (m_pos <= 2) ? SYM_SYNC : SYM_SSD;
                    end else if (TX_ER) begin
                        m_err = 1'b1;
                        m_sym = SYM_HALT;
                    end else m_sym = enc_tab[TXD];
                end
            end
            M_STATUS: begin
                m_sym  = m_err ? SYM_ESDERR : SYM_ESDOK;
                m_mode = M_DRAIN;
            end
            default: begin
                m_sym  = SYM_SILENCE;
                m_mode = M_IDLE;
            end
        endcase
    endtask

    // Model update plus per-cycle compare, 1 time unit after each edge.
    initial begin
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n || pcs_reset || link_control == LINK_DISABLE) model_reset();
            else if (STD) model_step();
            #1;
            if (chk_en) begin
                check("txn", TXn, m_sym);
                check("transmitting", transmitting, m_sym != SYM_SILENCE);
                check("tx_err", tx_err, m_err);
            end
        end
    end

    // One symbol period: inputs set at a negedge, STD high for one clk.
    task automatic step(input bit en, input bit er, input logic [3:0] d,
                        input logic [1:0] c, input int gap, output logic [4:0] s);
        TX_EN  = en;
        TX_ER  = er;
        TXD    = d;
        tx_cmd = c;
        STD    = 1'b1;
        @(posedge clk);
        #1;
        s = TXn;
        if (transmitting) tx_stds++;
        @(negedge clk);
        STD = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0] s [32];
        logic [4:0] tmp;
        logic [3:0] nib [20];
        bit         en_r;
        logic [1:0] cmd_r;

        repeat (3) @(negedge clk);
        check("reset_txn", TXn, 5'b11111);
        check("reset_transmitting", transmitting, 1'b0);
        check("reset_tx_err", tx_err, 1'b0);
        check("reset_state", mod_147_5_state, 4'd0);
        reset_n = 1'b1;
        chk_en  = 1'b1;
        repeat (2) @(negedge clk);

        // 20-nibble frame: preamble 0x5 x15, SFD 0xD, four data nibbles.
        for (int i = 0; i < 15; i++) nib[i] = 4'h5;
        nib[15] = 4'hD; nib[16] = 4'h3; nib[17] = 4'hA; nib[18] = 4'h0; nib[19] = 4'hF;
        tx_stds = 0;
        for (int i = 0; i < 20; i++) step(1'b1, 1'b0, nib[i], CMD_NONE, i % 2, s[i]);
        for (int i = 20; i < 23; i++) step(1'b0, 1'b0, 4'h0, CMD_NONE, 1, s[i]);
        check("frame_sync_first", s[0], 5'b11000);
        check("frame_ssd2", s[3], 5'b10001);
        check("frame_first_data", s[4], 5'b01011);
        check("frame_last_preamble", s[14], 5'b01011);
        check("frame_sfd", s[15], 5'b11011);
        check("frame_data0", s[16], 5'b10101);
        check("frame_data3", s[19], 5'b11101);
        check("frame_esd", s[20], 5'b01101);
        check("frame_esdok", s[21], 5'b00111);
        check("frame_silence", s[22], 5'b11111);
        check("frame_tx_len", tx_stds, 22);

        // TX_ER on the 7th nibble, inside DATA.
        for (int i = 0; i < 8; i++) begin
            step(1'b1, i == 6, 4'h9, CMD_NONE, 0, s[i]);
            if (i == 6) check("halt_tx_err", tx_err, 1'b1);
        end
        for (int i = 8; i < 11; i++) step(1'b0, 1'b0, 4'h0, CMD_NONE, 0, s[i]);
        check("halt_sym", s[6], 5'b00100);
        check("halt_resume", s[7], 5'b10011);
        check("halt_esderr", s[9], 5'b11001);

        // Runt frame: TX_EN drops while in SYNC2.
        for (int i = 0; i < 2; i++) step(1'b1, 1'b0, 4'h5, CMD_NONE, 1, s[i]);
        for (int i = 2; i < 5; i++) step(1'b0, 1'b0, 4'h0, CMD_NONE, 1, s[i]);
        check("runt_esd", s[2], 5'b01101);
        check("runt_esderr", s[3], 5'b11001);
        check("runt_silence", s[4], 5'b11111);

        // COMMIT for 5 STDs, then a 6-nibble frame with TX_EN taking over.
        tx_stds = 0;
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 4'h0, CMD_COMMIT, 0, s[i]);
        step(1'b1, 1'b0, 4'h5, CMD_COMMIT, 0, s[5]);
        for (int i = 6; i < 11; i++) step(1'b1, 1'b0, 4'h5, CMD_NONE, 0, s[i]);
        for (int i = 11; i < 14; i++) step(1'b0, 1'b0, 4'h0, CMD_NONE, 0, s[i]);
        check("commit_sync", s[4], 5'b11000);
        check("commit_sync1", s[5], 5'b11000);
        check("commit_ssd", s[7], 5'b10001);
        check("commit_tx_len", tx_stds, 13);

        // One STD of HEARTBEAT still yields two HB symbols.
        step(1'b0, 1'b0, 4'h0, CMD_HEARTBEAT, 1, s[0]);
        step(1'b0, 1'b0, 4'h0, CMD_NONE, 1, s[1]);
        step(1'b0, 1'b0, 4'h0, CMD_NONE, 1, s[2]);
        check("hb_first", s[0], 5'b00101);
        check("hb_second", s[1], 5'b00101);
        check("hb_end", s[2], 5'b11111);

        // DISABLE mid-DATA acts without STD and leaves no ESD.
        for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 4'h2, CMD_NONE, 0, tmp);
        link_control = LINK_DISABLE;
        @(posedge clk);
        #1;
        check("disable_txn", TXn, 5'b11111);
        check("disable_transmitting", transmitting, 1'b0);
        check("disable_state", mod_147_5_state, 4'd0);
        @(negedge clk);
        TX_EN = 1'b0;
        link_control = LINK_ENABLE;
        step(1'b0, 1'b0, 4'h0, CMD_NONE, 0, s[0]);
        check("disable_no_esd", s[0], 5'b11111);

        // reset_n pulse mid-frame with tx_err already set.
        for (int i = 0; i < 7; i++) step(1'b1, i == 1, 4'h7, CMD_NONE, 0, tmp);
        check("prereset_tx_err", tx_err, 1'b1);
        #3;
        reset_n = 1'b0;
        #1;
        check("areset_txn", TXn, 5'b11111);
        check("areset_transmitting", transmitting, 1'b0);
        check("areset_tx_err", tx_err, 1'b0);
        check("areset_state", mod_147_5_state, 4'd0);
        @(negedge clk);
        reset_n = 1'b1;
        TX_EN = 1'b0;
        @(negedge clk);

        // Randomized traffic against the model.
        en_r  = 1'b0;
        cmd_r = CMD_NONE;
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 7) == 0) en_r = !en_r;
            if ($urandom_range(0, 5) == 0) cmd_r = 2'($urandom_range(0, 3));
            pcs_reset    = ($urandom_range(0, 99) == 0);
            link_control = ($urandom_range(0, 149) != 0);
            step(en_r, $urandom_range(0, 15) == 0, 4'($urandom), cmd_r,
                 $urandom_range(0, 2), tmp);
        end
        pcs_reset    = 1'b0;
        link_control = LINK_ENABLE;
        repeat (4) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
